serial_addsub: RTL and testbench
================================

# serial_addsub

Parametrised multi-cycle adder/subtractor that processes a WIDTH-bit operand pair DIGIT bits per clock, LSB digit first, through one DIGIT-bit ripple-carry slice with a registered carry. It is the sequential, area-reduced successor to the team's fixed 4-bit ripple adder. It adds a subtract mode, signed-overflow detection and a start/done handshake, and it sits in datapaths where throughput can be traded for adder width.

## Interface
- WIDTH, 16, operand and result width in bits; must be a multiple of DIGIT.
- DIGIT, 4, bits processed per cycle; 1 ≤ DIGIT ≤ WIDTH. K = WIDTH/DIGIT is the number of cycles per operation.
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  reset, asynchronous and active-high.
- start  input  1  request; accepted on a rising edge when busy=0.
- sub  input  1  mode: 0 gives S = A + B + ci; 1 gives S = A − B (ci ignored).
- a  input  WIDTH  operand A, sampled only on an accepted start.
- b  input  WIDTH  operand B, sampled only on an accepted start.
- ci  input  1  carry-in for add mode, sampled only on an accepted start.
- busy  output  1  high while the operation is in progress (RUN state).
- done  output  1  single-cycle pulse; s, co and ovf are valid from this cycle onward.
- s  output  WIDTH  result, registered.
- co  output  1  carry-out of the MSB; in subtract mode 1 means no borrow (A ≥ B, unsigned).
- ovf  output  1  two's-complement overflow: carry into the MSB XOR carry out of the MSB.

## Operation
- States and transitions:
  - IDLE: start goes to RUN.
  - RUN: stays in RUN until the last digit is processed, then goes to DONE.
  - DONE: lasts one cycle. With start it goes to RUN; without start it goes to IDLE.
- Accept on start while in IDLE or DONE:
  - Latch a into the A shift register.
  - Latch b (sub=0) or ~b (sub=1) into the B shift register.
  - Initialise the carry register to ci (sub=0) or 1 (sub=1).
  - Clear the digit counter.
- Each RUN cycle:
  - Slice computes sum_d = A[DIGIT-1:0] + B[DIGIT-1:0] + carry.
  - Sum digit shifts into the MSB end of the result shift register.
  - A and B shift right by DIGIT.
  - Carry register takes the slice carry-out.
  - Counter increments.
- On the last digit (counter = K−1):
  - s is loaded with the completed result.
  - co takes the final carry.
  - ovf takes the carry into bit WIDTH−1 XOR co. This comes from the last slice's internal carry at position DIGIT−1.
  - Next state is DONE.
- s, co and ovf change only on the transition into DONE. They hold until the next completion or a reset.
- start in RUN is ignored: no restart and no queueing.
- Changes on a, b, sub or ci after acceptance have no effect on the operation in progress.
- Arithmetic is modulo 2^WIDTH. There are no internal sign extensions.

## Timing
- Reset values (asynchronous assertion):
  - state = IDLE, busy = 0, done = 0.
  - s = 0, co = 0, ovf = 0.
  - Counter, shift registers and carry are cleared.
- Reset mid-RUN aborts the operation: no done pulse, and outputs return to their reset values immediately.
- Latency: start is sampled at edge t. busy is high after edges t … t+K−1. done, s, co and ovf are updated at edge t+K, so done is high exactly one cycle (t+K to t+K+1).
- Throughput:
  - One result per K+1 cycles when start is held continuously.
  - start asserted in the done cycle is accepted; busy rises at the next edge with no IDLE gap.
- K=1 (DIGIT=WIDTH): one RUN cycle, then done. The block behaves as a registered single-cycle adder with a handshake.
- done is never high together with busy.

## Test plan
- WIDTH=16, DIGIT=4, add 0x1234 + 0x4321, ci=0 -> s=0x5555, co=0, ovf=0. done comes exactly 4 cycles after the accepting edge, and busy is high for 4 cycles.
- Add 0xFFFF + 0x0001, ci=0 -> s=0x0000, co=1, ovf=0. Add 0x7FFF + 0x0001 -> s=0x8000, co=0, ovf=1. Add 0x00FF + 0x0000, ci=1 -> s=0x0100.
- Subtract 0x0005 − 0x0007 with ci=1 (must be ignored) -> s=0xFFFE, co=0, ovf=0. Subtract 0x8000 − 0x0001 -> s=0x7FFF, co=1, ovf=1.
- Handshake sequence:
  - Pulse start mid-RUN with different operands: ignored, and the original result is produced.
  - Change a/b during RUN: no effect.
  - Assert start in the done cycle: the new op begins next edge, and its done comes 5 cycles after the previous done.
- Reset asserted asynchronously in RUN cycle 2: outputs go to 0 immediately, and no done follows. After release, 0x0001 + 0x0001 -> s=0x0002.
- Parameter sweep with a random-vector comparison against a + b + ci and a − b:
  - WIDTH=16, DIGIT=16 (done after 1 cycle).
  - WIDTH=16, DIGIT=1 (done after 16 cycles).
  - WIDTH=8, DIGIT=2.

Source files
------------

// File: rtl/serial_addsub.sv
// serial_addsub: digit-serial adder/subtractor, DIGIT bits per clock, LSB first.
// One DIGIT-bit ripple slice with a registered carry; start/busy/done handshake.
module serial_addsub #(
   parameter int WIDTH = 16,
   parameter int DIGIT = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             sub,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             ci,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] s,
   output logic             co,
   output logic             ovf
);

   localparam int K  = WIDTH / DIGIT;
   localparam int CW = (K > 1) ? $clog2(K) : 1;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } state_t;

   state_t state, state_next;

   logic [WIDTH-1:0] a_sr, b_sr, res_sr, res_next;
   logic             carry;
   logic [CW-1:0]    cnt;
   logic [DIGIT:0]   slice;
   logic             msb_cin;
   logic             last;
   logic             accept;

   assign slice = {1'b0, a_sr[DIGIT-1:0]}
                + {1'b0, b_sr[DIGIT-1:0]}
                + {{DIGIT{1'b0}}, carry};

   // carry into the slice MSB recovered from the sum bit and its operands
   assign msb_cin = slice[DIGIT-1] ^ a_sr[DIGIT-1] ^ b_sr[DIGIT-1];

   generate
      if (DIGIT == WIDTH) begin : g_single
         assign res_next = slice[DIGIT-1:0];
      end else begin : g_multi
         assign res_next = {slice[DIGIT-1:0], res_sr[WIDTH-1:DIGIT]};
      end
   endgenerate

   assign last   = (cnt == CW'(K - 1));
   assign accept = start && (state != RUN);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      busy       = 1'b0;
      done       = 1'b0;
      unique case (state)
         IDLE: begin
            if (start) state_next = RUN;
         end
         RUN: begin
            busy = 1'b1;
            if (last) state_next = DONE;
         end
         DONE: begin
            done       = 1'b1;
            state_next = start ? RUN : IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_sr   <= '0;
         b_sr   <= '0;
         res_sr <= '0;
         carry  <= 1'b0;
         cnt    <= '0;
         s      <= '0;
         co     <= 1'b0;
         ovf    <= 1'b0;
      end else if (accept) begin
         a_sr  <= a;
         b_sr  <= sub ? ~b : b;
         carry <= sub ? 1'b1 : ci;
         cnt   <= '0;
      end else if (state == RUN) begin
         a_sr   <= a_sr >> DIGIT;
         b_sr   <= b_sr >> DIGIT;
         carry  <= slice[DIGIT];
         cnt    <= cnt + CW'(1);
         res_sr <= res_next;
         if (last) begin
            s   <= res_next;
            co  <= slice[DIGIT];
            ovf <= msb_cin ^ slice[DIGIT];
         end
      end
   end

endmodule

// File: tb/tb_serial_addsub.sv
// tb_serial_addsub: directed checks on a 16/4 instance plus random sweeps
// on 16/16, 16/1 and 8/2 instances against an arithmetic model.
module tb_serial_addsub;

   logic        clk;
   logic        rst;
   logic        st   [4];
   logic        sb   [4];
   logic        cin  [4];
   logic [15:0] av   [4];
   logic [15:0] bv   [4];
   logic        bz   [4];
   logic        dn   [4];
   logic        cov  [4];
   logic        ovv  [4];
   logic [15:0] s0, s1, s2;
   logic [7:0]  s3;

   int n_checks;
   int n_fail;

   serial_addsub #(.WIDTH(16), .DIGIT(4)) u0 (
      .clk(clk), .rst(rst), .start(st[0]), .sub(sb[0]),
      .a(av[0]), .b(bv[0]), .ci(cin[0]), .busy(bz[0]),
      .done(dn[0]), .s(s0), .co(cov[0]), .ovf(ovv[0]));

   serial_addsub #(.WIDTH(16), .DIGIT(16)) u1 (
      .clk(clk), .rst(rst), .start(st[1]), .sub(sb[1]),
      .a(av[1]), .b(bv[1]), .ci(cin[1]), .busy(bz[1]),
      .done(dn[1]), .s(s1), .co(cov[1]), .ovf(ovv[1]));

   serial_addsub #(.WIDTH(16), .DIGIT(1)) u2 (
      .clk(clk), .rst(rst), .start(st[2]), .sub(sb[2]),
      .a(av[2]), .b(bv[2]), .ci(cin[2]), .busy(bz[2]),
      .done(dn[2]), .s(s2), .co(cov[2]), .ovf(ovv[2]));

   serial_addsub #(.WIDTH(8), .DIGIT(2)) u3 (
      .clk(clk), .rst(rst), .start(st[3]), .sub(sb[3]),
      .a(av[3][7:0]), .b(bv[3][7:0]), .ci(cin[3]), .busy(bz[3]),
      .done(dn[3]), .s(s3), .co(cov[3]), .ovf(ovv[3]));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [15:0] s_of(input int k);
      case (k)
         0: return s0;
         1: return s1;
         2: return s2;
         default: return {8'h00, s3};
      endcase
   endfunction

   task automatic do_op(input int k, input bit now, input bit scramble,
                        input logic sb_i, input logic [15:0] x,
                        input logic [15:0] y, input logic c,
                        output logic [15:0] rs, output logic rco,
                        output logic rovf, output int lat, output int bc);
      if (!now) @(negedge clk);
      sb[k]  = sb_i;
      av[k]  = x;
      bv[k]  = y;
      cin[k] = c;
      st[k]  = 1'b1;
      @(posedge clk);
      #1;
      st[k] = 1'b0;
      lat   = 0;
      bc    = 0;
      while (!dn[k] && lat < 40) begin
         if (bz[k]) bc++;
         if (scramble && lat == 1) begin
            st[k]  = 1'b1;
            av[k]  = ~x;
            bv[k]  = 16'h0F0F;
            sb[k]  = ~sb_i;
            cin[k] = ~c;
         end
         if (scramble && lat == 2) st[k] = 1'b0;
         @(posedge clk);
         #1;
         lat++;
      end
      rs   = s_of(k);
      rco  = cov[k];
      rovf = ovv[k];
   endtask

   // returns {ovf, co, s}
   function automatic logic [17:0] model(input int w, input logic sb_i,
                                         input logic [15:0] x,
                                         input logic [15:0] y,
                                         input logic c);
      logic [15:0] m, xm, ym, r;
      logic [16:0] full;
      logic        o, cy;
      m  = (w == 16) ? 16'hFFFF : 16'h00FF;
      xm = x & m;
      ym = y & m;
      if (sb_i) begin
         r  = (xm - ym) & m;
         cy = (xm >= ym);
         o  = (xm[w-1] != ym[w-1]) && (r[w-1] != xm[w-1]);
      end else begin
         full = {1'b0, xm} + {1'b0, ym} + {16'h0000, c};
         r    = full[15:0] & m;
         cy   = full[w];
         o    = (xm[w-1] == ym[w-1]) && (r[w-1] != xm[w-1]);
      end
      return {o, cy, r};
   endfunction

   initial begin
      logic [15:0] rs, x, y;
      logic        rco, rovf, c, sbit, seen;
      logic [17:0] e;
      int          lat, bc, kk, ww;
      int          klat[4];
      int          kwid[4];
      string       tg;

      n_checks = 0;
      n_fail   = 0;
      klat = '{4, 1, 16, 4};
      kwid = '{16, 16, 16, 8};
      for (int i = 0; i < 4; i++) begin
         st[i] = 1'b0; sb[i] = 1'b0; cin[i] = 1'b0;
         av[i] = '0;   bv[i] = '0;
      end
      rst = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;

      check("rst_busy", bz[0], 0);
      check("rst_done", dn[0], 0);
      check("rst_s", s0, 0);
      check("rst_co", cov[0], 0);
      check("rst_ovf", ovv[0], 0);

      do_op(0, 0, 0, 0, 16'h1234, 16'h4321, 0, rs, rco, rovf, lat, bc);
      check("add1_s", rs, 16'h5555);
      check("add1_co", rco, 0);
      check("add1_ovf", rovf, 0);
      check("add1_lat", lat, 4);
      check("add1_busy", bc, 4);
      check("add1_busy_in_done", bz[0], 0);
      @(posedge clk);
      #1;
      check("done_pulse", dn[0], 0);
      check("hold_s", s0, 16'h5555);

      do_op(0, 0, 0, 0, 16'hFFFF, 16'h0001, 0, rs, rco, rovf, lat, bc);
      check("wrap_s", rs, 16'h0000);
      check("wrap_co", rco, 1);
      check("wrap_ovf", rovf, 0);
      do_op(0, 0, 0, 0, 16'h7FFF, 16'h0001, 0, rs, rco, rovf, lat, bc);
      check("povf_s", rs, 16'h8000);
      check("povf_co", rco, 0);
      check("povf_ovf", rovf, 1);
      do_op(0, 0, 0, 0, 16'h00FF, 16'h0000, 1, rs, rco, rovf, lat, bc);
      check("ci_s", rs, 16'h0100);
      check("ci_co", rco, 0);

      do_op(0, 0, 0, 1, 16'h0005, 16'h0007, 1, rs, rco, rovf, lat, bc);
      check("sub1_s", rs, 16'hFFFE);
      check("sub1_co", rco, 0);
      check("sub1_ovf", rovf, 0);
      do_op(0, 0, 0, 1, 16'h8000, 16'h0001, 0, rs, rco, rovf, lat, bc);
      check("sub2_s", rs, 16'h7FFF);
      check("sub2_co", rco, 1);
      check("sub2_ovf", rovf, 1);

      do_op(0, 0, 1, 0, 16'h1111, 16'h2222, 0, rs, rco, rovf, lat, bc);
      check("scr_s", rs, 16'h3333);
      check("scr_co", rco, 0);
      check("scr_lat", lat, 4);
      do_op(0, 1, 0, 1, 16'h1000, 16'h0001, 0, rs, rco, rovf, lat, bc);
      check("b2b_s", rs, 16'h0FFF);
      check("b2b_co", rco, 1);
      check("b2b_gap", lat + 1, 5);
      check("b2b_busy", bc, 4);

      @(negedge clk);
      av[0] = 16'hAAAA; bv[0] = 16'h5555; sb[0] = 0; cin[0] = 0;
      st[0] = 1'b1;
      @(posedge clk);
      #1;
      st[0] = 1'b0;
      @(posedge clk);
      #3;
      rst = 1'b1;
      #1;
      check("arst_s", s0, 0);
      check("arst_co", cov[0], 0);
      check("arst_busy", bz[0], 0);
      @(posedge clk);
      @(negedge clk);
      rst  = 1'b0;
      seen = 1'b0;
      repeat (8) begin
         @(posedge clk);
         #1;
         if (dn[0]) seen = 1'b1;
      end
      check("arst_nodone", seen, 0);
      do_op(0, 0, 0, 0, 16'h0001, 16'h0001, 0, rs, rco, rovf, lat, bc);
      check("post_rst_s", rs, 16'h0002);

      for (int k = 1; k < 4; k++) begin
         kk = klat[k];
         ww = kwid[k];
         for (int i = 0; i < 10; i++) begin
            sbit = i[0];
            x    = 16'($urandom);
            y    = 16'($urandom);
            c    = 1'($urandom);
            if (i < 2) begin
               x = 16'hFFFF;
               y = 16'h0001;
            end
            e = model(ww, sbit, x, y, c);
            do_op(k, 0, 0, sbit, x, y, c, rs, rco, rovf, lat, bc);
            tg = $sformatf("sw%0d_%0d", k, i);
            check({tg, "_s"}, rs, e[15:0]);
            check({tg, "_co"}, rco, e[16]);
            check({tg, "_ovf"}, rovf, e[17]);
            check({tg, "_lat"}, lat, kk);
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

endmodule
